sram_controller: RTL and testbench
==================================

# sram_controller

Memory-stage bridge between the 32-bit data path and a 16-bit external asynchronous SRAM. It accepts the load/store request formed by the execute stage: the effective address from the ALU result, the store data from the forwarded Rm value, and the read/write enables. It performs each 32-bit word as two 16-bit SRAM accesses and stalls the pipeline through `ready` until the word completes. The pipeline freeze logic uses `~ready` to hold every stage register while a transfer is in flight.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `WAIT_CYCLES`, 2: clock cycles each 16-bit half-access is held on the SRAM pins (≥1).
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rd_en` in 1: load request; held stable by the pipeline until `ready`.
- `wr_en` in 1: store request; held stable until `ready`.
- `address` in 32: byte address of the access.
- `write_data` in 32: store data.
- `read_data` out 32: last completed load word.
- `ready` out 1: 1 when no access is pending or the current access completes this cycle.
- `SRAM_DQ` inout 16: SRAM data bus; high-Z unless writing.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N` out 1: active-low write strobe.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N` out 1 each: tied to 0.

## Operation
- Word address `wa = (address - BASE_ADDR) >> 2`, with a 32-bit subtract. Half address is `SRAM_ADDR = {wa[16:0], h}`, where h=0 is the low half and h=1 is the high half. Out-of-range addresses wrap silently.
- FSM states: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - If `wr_en|rd_en`, latch `address`, `write_data` and the operation (write wins if both are set), clear the counter and go to LOW.
  - Otherwise stay in IDLE.
- **LOW**
  - Drive the half address with h=0.
  - For writes, drive `SRAM_DQ = data[15:0]` and `SRAM_WE_N=0`.
  - Count `WAIT_CYCLES` cycles.
  - On the last cycle, reads capture `SRAM_DQ` into the low half of the read buffer. Then go to HIGH with the counter cleared.
- **HIGH**: same as LOW with h=1 and `data[31:16]`. Reads capture the high half on the last cycle, then go to DONE.
- **DONE**
  - One cycle. `read_data` updates from the buffer for loads only; stores leave it unchanged.
  - Go to IDLE.
- `ready` is combinational:
  - IDLE: `~(rd_en|wr_en)`.
  - LOW, HIGH: 0.
  - DONE: 1.
- Latched operands are used for the whole transfer. A request dropped or changed mid-transfer does not alter it, and the transfer still completes.
- `SRAM_WE_N` is 1 and `SRAM_DQ` is high-Z in IDLE, in DONE, and during reads.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `read_data=0`.
  - `SRAM_ADDR=0`, `SRAM_WE_N=1`, `SRAM_DQ` high-Z.
  - `ready` follows IDLE rules.
- Request first seen high in IDLE at cycle t:
  - LOW occupies t+1 … t+W.
  - HIGH occupies t+W+1 … t+2W.
  - DONE is cycle t+2W+1.
  - `ready` is low for 2W+1 cycles (5 at W=2) and high in the DONE cycle. The pipeline advances on the edge ending DONE.
- Back-to-back accesses: DONE is always followed by IDLE. A new request held at that IDLE cycle has `ready=0` there and starts LOW the next cycle. There is no overlap between accesses.
- `read_data` is valid from the cycle after DONE and is held until the next load's DONE.
- Reset mid-transfer:
  - Asynchronously forces IDLE.
  - `SRAM_WE_N=1` and `SRAM_DQ` to high-Z immediately.
  - `read_data` returns to 0.
  - A partial store may leave one half written; this is acceptable.
- Registered SRAM outputs: `SRAM_ADDR` and `SRAM_WE_N` change only on clock edges, except on asynchronous reset.

## Test plan
- Idle, no request for 10 cycles → `ready=1` throughout, `SRAM_WE_N=1`, `SRAM_DQ` high-Z.
- Store 0x12345678 to address 1024 (W=2) → `ready` low 5 cycles, high on the 6th. SRAM sees addr 0 / 0x5678 with `WE_N=0` for 2 cycles, then addr 1 / 0x1234 for 2 cycles.
- Load from 1024 after the store → `ready` high in cycle 6 and `read_data=0x12345678` from cycle 7. `SRAM_WE_N` stays 1.
- Store 0xDEADBEEF to 1028, then load 1028 immediately → SRAM_ADDR 2/3 used. The load starts the cycle after the store's DONE, with one IDLE cycle between them. It returns 0xDEADBEEF, and the word at 1024 is unchanged.
- Request with both `rd_en=1` and `wr_en=1` → treated as a write, and `read_data` is unchanged.
- Assert `rst` during HIGH of a store → `SRAM_WE_N=1` and DQ high-Z in the same cycle, then IDLE with `read_data=0`. A following load of 1028 completes normally in 6 cycles.

Source files
------------

// File: rtl/sram_controller.sv
// Bridges 32-bit load/store requests to a 16-bit asynchronous SRAM as two half-word accesses,
// stalling the pipeline through ready until the word completes.
module sram_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            is_wr_q, is_wr_d;
  logic [16:0]     wa_q, wa_d;
  logic [15:0]     data_hi_q, data_hi_d;
  logic [31:0]     buf_q, buf_d;
  logic [31:0]     read_data_q, read_data_d;
  logic [17:0]     addr_q, addr_d;
  logic            we_n_q, we_n_d;
  logic            dq_oe_q, dq_oe_d;
  logic [15:0]     dq_out_q, dq_out_d;

  logic [31:0] offset;
  logic [16:0] wa_in;
  logic        req;
  logic        unused_offset;

  // Only word-address bits [18:2] reach the SRAM; everything else wraps silently.
  assign offset        = address - BASE_ADDR;
  assign wa_in         = offset[18:2];
  assign unused_offset = ^{offset[31:19], offset[1:0]};
  assign req           = rd_en | wr_en;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    wa_d        = wa_q;
    data_hi_d   = data_hi_q;
    buf_d       = buf_q;
    read_data_d = read_data_q;
    addr_d      = addr_q;
    we_n_d      = we_n_q;
    dq_oe_d     = dq_oe_q;
    dq_out_d    = dq_out_q;
    ready       = 1'b0;

    // SRAM pin values are set one cycle early so they are registered for the next state.
    unique case (state_q)
      StIdle: begin
        ready = ~req;
        if (req) begin
          state_d   = StLow;
          cnt_d     = '0;
          is_wr_d   = wr_en;
          wa_d      = wa_in;
          data_hi_d = write_data[31:16];
          addr_d    = {wa_in, 1'b0};
          we_n_d    = ~wr_en;
          dq_oe_d   = wr_en;
          dq_out_d  = write_data[15:0];
        end
      end
      StLow: begin
        if (cnt_q == CntLast) begin
          state_d  = StHigh;
          cnt_d    = '0;
          addr_d   = {wa_q, 1'b1};
          dq_out_d = data_hi_q;
          if (!is_wr_q) buf_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (cnt_q == CntLast) begin
          state_d = StDone;
          cnt_d   = '0;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          if (!is_wr_q) buf_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
        if (!is_wr_q) read_data_d = buf_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      wa_q        <= '0;
      data_hi_q   <= '0;
      buf_q       <= '0;
      read_data_q <= '0;
      addr_q      <= '0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      wa_q        <= wa_d;
      data_hi_q   <= data_hi_d;
      buf_q       <= buf_d;
      read_data_q <= read_data_d;
      addr_q      <= addr_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM behavioural model, word-level reference model with a per-cycle
// compare process, directed scenarios and randomized load/store traffic.
module tb_sram_controller;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, ub_n, lb_n, ce_n, oe_n;

  always #5 clk = ~clk;

  sram_controller #(
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .wr_en     (wr_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n)
  );

  // Asynchronous SRAM: drives the bus whenever not being written.
  logic [15:0] sram [0:262143];
  assign sram_dq = we_n ? sram[sram_addr] : 16'hzzzz;
  always @(posedge clk) if (!we_n) sram[sram_addr] <= sram_dq;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  // Word-level reference model.
  logic [31:0] ref_mem [logic [16:0]];
  int          m_k = 0;  // 0 idle, else cycle index 1..2W+1 within the access
  logic        m_wr = 1'b0;
  logic [16:0] m_wa = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_rd = '0;
  logic [17:0] m_addr = '0;

  function automatic logic [16:0] wa_of(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) / 4;
    return w[16:0];
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_k = 0;
      m_rd = '0;
      m_addr = '0;
    end else begin
      if (m_k == 0) begin
        if (rd_en || wr_en) begin
          m_k = 1;
          m_wr = wr_en;
          m_wa = wa_of(address);
          m_data = write_data;
        end
      end else if (m_k == 2 * W + 1) begin
        m_k = 0;
        if (m_wr) ref_mem[m_wa] = m_data;
        else m_rd = ref_rd(m_wa);
      end else begin
        m_k++;
      end
      if (m_k >= 1 && m_k <= W) m_addr = {m_wa, 1'b0};
      else if (m_k > W && m_k <= 2 * W) m_addr = {m_wa, 1'b1};
    end
  end

  // Compare process: every cycle, away from the rising edge.
  initial forever begin
    logic exp_ready, exp_we_n;
    @(negedge clk);
    exp_ready = (m_k == 0) ? !(rd_en || wr_en) : (m_k == 2 * W + 1);
    exp_we_n  = !(m_wr && m_k >= 1 && m_k <= 2 * W);
    chk("ready", 32'(ready), 32'(exp_ready));
    chk("sram_we_n", 32'(we_n), 32'(exp_we_n));
    chk("sram_addr", 32'(sram_addr), 32'(m_addr));
    chk("read_data", read_data, m_rd);
    chk("tied_pins", 32'({ub_n, lb_n, ce_n, oe_n}), 32'h0);
  end

  logic [17:0] log_addr [$];
  logic        log_we [$];

  // Called at posedge+1 with the DUT idle; returns at posedge+1 just after DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int low_cnt);
    int budget;
    rd_en = rd;
    wr_en = wr;
    address = a;
    write_data = d;
    low_cnt = 0;
    budget = 0;
    log_addr.delete();
    log_we.delete();
    forever begin
      @(negedge clk);
      log_addr.push_back(sram_addr);
      log_we.push_back(we_n);
      if (ready) break;
      low_cnt++;
      budget++;
      if (budget > 40) begin
        n_chk++;
        $display("FAIL ready_timeout: ready still 0 after %0d cycles, expected 1", budget);
        break;
      end
    end
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = $urandom;
    write_data = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lc, hi_cnt, any_we;
    logic [31:0] a, d;
    int op;
    for (int i = 0; i < 262144; i++) sram[i] = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    hi_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      hi_cnt += int'(ready);
    end
    chk("idle_ready_cycles", 32'(hi_cnt), 32'd10);
    idle(1);

    access(1'b0, 1'b1, 32'd1024, 32'h12345678, lc);
    chk("st_ready_low", 32'(lc), 32'd5);
    chk("st_lo_addr", 32'(log_addr[1]), 32'd0);
    chk("st_lo_we", 32'(log_we[2]), 32'd0);
    chk("st_hi_addr", 32'(log_addr[3]), 32'd1);
    chk("st_hi_we", 32'(log_we[4]), 32'd0);
    chk("st_done_we", 32'(log_we[5]), 32'd1);
    chk("sram0", 32'(sram[0]), 32'h5678);
    chk("sram1", 32'(sram[1]), 32'h1234);

    access(1'b1, 1'b0, 32'd1024, 32'h0, lc);
    chk("ld_ready_low", 32'(lc), 32'd5);
    chk("ld_1024", read_data, 32'h12345678);
    any_we = 0;
    foreach (log_we[i]) if (!log_we[i]) any_we++;
    chk("ld_no_we", 32'(any_we), 32'd0);

    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, lc);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lc);
    chk("b2b_idle_ready", 32'(log_we[0]), 32'd1);
    chk("b2b_ld_lo_addr", 32'(log_addr[1]), 32'd2);
    chk("b2b_ld_hi_addr", 32'(log_addr[3]), 32'd3);
    chk("ld_1028", read_data, 32'hDEADBEEF);
    chk("sram2", 32'(sram[2]), 32'hBEEF);
    chk("sram3", 32'(sram[3]), 32'hDEAD);
    access(1'b1, 1'b0, 32'd1024, 32'h0, lc);
    chk("ld_1024_again", read_data, 32'h12345678);

    access(1'b1, 1'b1, 32'd1032, 32'h0BADCAFE, lc);
    chk("both_rd_keep", read_data, 32'h12345678);
    chk("sram4", 32'(sram[4]), 32'hCAFE);
    chk("sram5", 32'(sram[5]), 32'h0BAD);

    // Reset during the first HIGH cycle of a store: only the low half lands.
    wr_en = 1'b1;
    address = 32'd1028;
    write_data = 32'hCAFEF00D;
    repeat (W + 2) @(negedge clk);
    #2;
    rst = 1'b1;
    wr_en = 1'b0;
    #1;
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ref_mem[wa_of(32'd1028)] = 32'hDEADF00D;
    access(1'b1, 1'b0, 32'd1028, 32'h0, lc);
    chk("post_rst_ready_low", 32'(lc), 32'd5);
    chk("post_rst_ld", read_data, 32'hDEADF00D);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      d = $urandom;
      idle(int'($urandom_range(0, 2)));
      access(op == 0 || op == 2 || op == 3, op == 1 || op == 2, a, d, lc);
      chk("rand_ready_low", 32'(lc), 32'(2 * W + 1));
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
